store_trace_fifo: RTL

//  Captures every data-memory store the RISC_V core issues (addr, data, PC) into a FIFO.

---
 rtl/store_trace_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/store_trace_fifo.sv
// store_trace_fifo: captures every data-memory store (address, data, PC) issued
// by the core into a first-word-fall-through FIFO drained over valid/ready.
// Stores arriving while the FIFO is full and not draining are counted as drops.
// Optional build macro STF_ADDR_FILTER_EN: when defined, only stores whose
// address lies in [FILT_BASE, FILT_LIMIT] are captured; others are ignored.
module store_trace_fifo #(
    parameter int              DEPTH_LOG2 = 3,
    parameter int              AW         = 32,
    parameter int              DW         = 32,
    parameter logic [AW-1:0]   FILT_BASE  = '0,
    parameter logic [AW-1:0]   FILT_LIMIT = AW'(255)
) (
    input  logic                  STF_IN_CLK,
    input  logic                  STF_IN_RST_N,
    input  logic                  STF_IN_MEMWRITE,
    input  logic [AW-1:0]         STF_IN_ADDR,
    input  logic [DW-1:0]         STF_IN_WR_DATA,
    input  logic [AW-1:0]         STF_IN_PC,
    input  logic                  STF_IN_READY,
    output logic                  STF_OUT_VALID,
    output logic [AW-1:0]         STF_OUT_ADDR,
    output logic [DW-1:0]         STF_OUT_DATA,
    output logic [AW-1:0]         STF_OUT_PC,
    output logic                  STF_OUT_FULL,
    output logic                  STF_OUT_EMPTY,
    output logic [DEPTH_LOG2:0]   STF_OUT_COUNT,
    output logic [15:0]           STF_OUT_DROP_CNT
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_MAX = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    // Storage is deliberately not reset; pointers and count define validity.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic full, empty;
    logic push_req, pop, push_ok, drop;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);

`ifdef STF_ADDR_FILTER_EN
    // Out-of-window stores never become push requests, so they cannot be drops.
    assign push_req = STF_IN_MEMWRITE &&
                      (STF_IN_ADDR >= FILT_BASE) && (STF_IN_ADDR <= FILT_LIMIT);
`else
    assign push_req = STF_IN_MEMWRITE;
`endif

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign pop     = !empty && STF_IN_READY;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge STF_IN_CLK or negedge STF_IN_RST_N) begin
        if (!STF_IN_RST_N) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage write; accepted stores land at the write pointer.
    always_ff @(posedge STF_IN_CLK) begin
        if (push_ok) begin
            addr_mem[wptr_q] <= STF_IN_ADDR;
            data_mem[wptr_q] <= STF_IN_WR_DATA;
            pc_mem[wptr_q]   <= STF_IN_PC;
        end
    end

    // Head entry falls through combinationally; fields read as zero when empty.
    always_comb begin
        STF_OUT_ADDR = '0;
        STF_OUT_DATA = '0;
        STF_OUT_PC   = '0;
        if (!empty) begin
            STF_OUT_ADDR = addr_mem[rptr_q];
            STF_OUT_DATA = data_mem[rptr_q];
            STF_OUT_PC   = pc_mem[rptr_q];
        end
    end

    assign STF_OUT_VALID    = !empty;
    assign STF_OUT_FULL     = full;
    assign STF_OUT_EMPTY    = empty;
    assign STF_OUT_COUNT    = count_q;
    assign STF_OUT_DROP_CNT = drop_cnt_q;

endmodule
